// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Issue / operand-fetch stage sitting directly in front of the ALU.
//
// A decoded instruction is accepted over a valid/ready handshake into a
// one-entry issue slot. While the instruction sits in the slot, the stage
// works out which registers it needs. It checks them against a pending-write
// scoreboard and reads them from the register file, with a bypass from the
// writeback port in the same cycle. When the instruction is free of hazards
// and the output register can take it, the instruction and its operands move
// into a registered bundle. Each field of that bundle drives the matching
// ALU input.
//
// The writeback port is shared by every result producer, including the ALU
// itself. A write clears the pending bit of its register and can release a
// stalled instruction on the same edge.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   in_valid / in_ready        instruction handshake into the issue slot
//   in_imm, in_mov, in_funct   instruction form and one-hot operation select
//   in_src1, in_src2, in_dest  register indices (or immediate bytes)
//   wb_en, wb_addr, wb_data    shared register writeback port
//   out_valid / out_ready      operand bundle handshake (out_valid = ALU en)
//   out_imm .. out_dest        registered copies of the instruction fields
//   out_read1, out_read2,      operands for ALU read1 / read2 / read_dest
//   out_read_dest
//
// Register index = low REG_BITS bits of each 8-bit index field. REG_BITS must
// be below 8. Register 0 always reads as zero and is never marked pending.
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int REG_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_imm,
  input  logic        in_mov,
  input  logic [3:0]  in_funct,
  input  logic [7:0]  in_src1,
  input  logic [7:0]  in_src2,
  input  logic [7:0]  in_dest,

  input  logic        wb_en,
  input  logic [7:0]  wb_addr,
  input  logic [31:0] wb_data,

  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_imm,
  output logic        out_mov,
  output logic [3:0]  out_funct,
  output logic [7:0]  out_src1,
  output logic [7:0]  out_src2,
  output logic [7:0]  out_dest,
  output logic [31:0] out_read1,
  output logic [31:0] out_read2,
  output logic [31:0] out_read_dest
);

  localparam int NUM_REGS = 1 << REG_BITS;

  typedef logic [REG_BITS-1:0] reg_idx_t;

  // Instruction fields as they travel through the issue slot.
  typedef struct packed {
    logic       imm;
    logic       mov;
    logic [3:0] funct;
    logic [7:0] src1;
    logic [7:0] src2;
    logic [7:0] dest;
  } instr_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                slot_valid_q;
  instr_t              slot_q;
  logic [31:0]         rf_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // ---------------------------------------------------------------------------
  // Writeback decode
  // ---------------------------------------------------------------------------
  reg_idx_t wb_idx;
  logic     wb_live;    // a real write: index 0 is discarded
  logic     unused_wb_hi;

  assign wb_idx       = wb_addr[REG_BITS-1:0];
  assign wb_live      = wb_en && (wb_idx != '0);
  // The upper index bits are ignored by definition.
  assign unused_wb_hi = ^wb_addr[7:REG_BITS];

  // ---------------------------------------------------------------------------
  // Slot decode: which registers the waiting instruction needs
  // ---------------------------------------------------------------------------
  reg_idx_t s1_idx, s2_idx, d_idx;
  logic     need_src1, need_src2, need_rdest;

  assign s1_idx = slot_q.src1[REG_BITS-1:0];
  assign s2_idx = slot_q.src2[REG_BITS-1:0];
  assign d_idx  = slot_q.dest[REG_BITS-1:0];

  // Register-register forms read both sources. Immediate ALU forms read src1
  // only, because src2 carries the immediate byte. Moves read no source. movh
  // keeps the untouched half of dest, so it reads dest as an operand.
  assign need_src1  = !(slot_q.imm && slot_q.mov);
  assign need_src2  = !slot_q.imm;
  assign need_rdest = slot_q.imm && slot_q.mov && slot_q.funct[1];

  // A register blocks issue only if it is pending and this cycle's writeback
  // is not delivering it. In that case the bypass supplies the value.
  logic blk_src1, blk_src2, blk_dest, hazard;

  assign blk_src1 = (s1_idx != '0) && pending_q[s1_idx] && !(wb_live && wb_idx == s1_idx);
  assign blk_src2 = (s2_idx != '0) && pending_q[s2_idx] && !(wb_live && wb_idx == s2_idx);
  assign blk_dest = (d_idx  != '0) && pending_q[d_idx]  && !(wb_live && wb_idx == d_idx);

  // dest is always checked (WAW). That check also covers the movh read of dest.
  assign hazard = (need_src1 && blk_src1) || (need_src2 && blk_src2) || blk_dest;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic issue, accept;

  assign issue    = slot_valid_q && !hazard && (!out_valid || out_ready);
  assign in_ready = !slot_valid_q || issue;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Operand read with same-cycle writeback bypass
  // ---------------------------------------------------------------------------
  logic [31:0] op1, op2, op_dest;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned; otherwise synthesis infers a latch.
    op1     = '0;
    op2     = '0;
    op_dest = '0;
    if (need_src1 && s1_idx != '0)
      op1 = (wb_live && wb_idx == s1_idx) ? wb_data : rf_q[s1_idx];
    if (need_src2 && s2_idx != '0)
      op2 = (wb_live && wb_idx == s2_idx) ? wb_data : rf_q[s2_idx];
    if (need_rdest && d_idx != '0)
      op_dest = (wb_live && wb_idx == d_idx) ? wb_data : rf_q[d_idx];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard update: writeback clears, issue sets. The set is applied last,
  // so it wins when both hit the same index.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    if (wb_live)
      pending_d[wb_idx] = 1'b0;
    if (issue && d_idx != '0)
      pending_d[d_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this register file is specified to come out of reset all-zero,
      // so it is built from resettable flops and cannot map onto a RAM macro.
      for (int i = 0; i < NUM_REGS; i++)
        rf_q[reg_idx_t'(i)] <= '0;
    end else if (wb_live) begin
      rf_q[wb_idx] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue slot, scoreboard and output bundle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, independent of statement order.
    if (reset) begin
      slot_valid_q  <= 1'b0;
      slot_q        <= '0;
      pending_q     <= '0;
      out_valid     <= 1'b0;
      out_imm       <= 1'b0;
      out_mov       <= 1'b0;
      out_funct     <= '0;
      out_src1      <= '0;
      out_src2      <= '0;
      out_dest      <= '0;
      out_read1     <= '0;
      out_read2     <= '0;
      out_read_dest <= '0;
    end else begin
      pending_q <= pending_d;

      // A slot that issues and accepts in the same cycle stays full.
      if (accept) begin
        slot_valid_q <= 1'b1;
        slot_q       <= '{imm: in_imm, mov: in_mov, funct: in_funct,
                          src1: in_src1, src2: in_src2, dest: in_dest};
      end else if (issue) begin
        slot_valid_q <= 1'b0;
      end

      // Fields change only on issue, so they stay stable while the bundle
      // is held with out_ready low.
      if (issue) begin
        out_valid     <= 1'b1;
        out_imm       <= slot_q.imm;
        out_mov       <= slot_q.mov;
        out_funct     <= slot_q.funct;
        out_src1      <= slot_q.src1;
        out_src2      <= slot_q.src2;
        out_dest      <= slot_q.dest;
        out_read1     <= op1;
        out_read2     <= op2;
        out_read_dest <= op_dest;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed bench for alu_operand_stage. A behavioural model of the stage
// (register array, pending set, slot and bundle variables) advances on each
// rising edge. A compare process checks the DUT against this model on every
// falling edge. The directed sequence also pins hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  localparam logic [3:0] F_ADD = 4'b0001;
  localparam logic [3:0] F_SUB = 4'b0010;
  localparam logic [3:0] F_AND = 4'b0100;
  localparam logic [3:0] F_OR  = 4'b1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_imm, in_mov;
  logic [3:0]  in_funct;
  logic [7:0]  in_src1, in_src2, in_dest;
  logic        wb_en;
  logic [7:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready, out_imm, out_mov;
  logic [3:0]  out_funct;
  logic [7:0]  out_src1, out_src2, out_dest;
  logic [31:0] out_read1, out_read2, out_read_dest;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_operand_stage #(.REG_BITS(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mov(in_mov), .in_funct(in_funct),
    .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_mov(out_mov), .out_funct(out_funct),
    .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
    .out_read1(out_read1), .out_read2(out_read2), .out_read_dest(out_read_dest)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       imm;
    logic       mov;
    logic [3:0] funct;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] d;
  } ins_t;

  logic [31:0] m_rf [64];
  bit   [63:0] m_pend;
  bit          m_slot_v, m_out_v;
  ins_t        m_slot, m_out;
  logic [31:0] m_r1, m_r2, m_rd;

  function automatic int ix(input logic [7:0] f);
    return int'(f) % 64;
  endfunction

  function automatic bit wb_hits(input int r);
    return wb_en && ix(wb_addr) == r;
  endfunction

  // Value a register read sees this cycle.
  function automatic logic [31:0] mval(input logic [7:0] f);
    int r;
    r = ix(f);
    if (r == 0) return 32'h0;
    if (wb_hits(r)) return wb_data;
    return m_rf[r];
  endfunction

  function automatic bit reads_src1(input ins_t i);
    return !(i.imm && i.mov);
  endfunction

  function automatic bit m_stalled();
    int need[$];
    need.push_back(ix(m_slot.d));
    if (reads_src1(m_slot)) need.push_back(ix(m_slot.s1));
    if (!m_slot.imm)        need.push_back(ix(m_slot.s2));
    foreach (need[k])
      if (need[k] != 0 && m_pend[need[k]] && !wb_hits(need[k])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_issue();
    return m_slot_v && !m_stalled() && (!m_out_v || out_ready);
  endfunction

  function automatic bit m_in_ready();
    return !m_slot_v || m_issue();
  endfunction

  always @(posedge clk) begin
    bit iss, acc;
    if (reset) begin
      m_slot_v = 1'b0;
      m_out_v  = 1'b0;
      m_slot   = '0;
      m_out    = '0;
      m_r1     = '0;
      m_r2     = '0;
      m_rd     = '0;
      m_pend   = '0;
      foreach (m_rf[k]) m_rf[k] = '0;
    end else begin
      iss = m_issue();
      acc = in_valid && (!m_slot_v || iss);
      if (iss) begin
        m_out   = m_slot;
        m_out_v = 1'b1;
        m_r1    = reads_src1(m_slot) ? mval(m_slot.s1) : 32'h0;
        m_r2    = !m_slot.imm ? mval(m_slot.s2) : 32'h0;
        m_rd    = (m_slot.imm && m_slot.mov && m_slot.funct[1]) ? mval(m_slot.d) : 32'h0;
      end else if (out_ready) begin
        m_out_v = 1'b0;
      end
      if (wb_en && ix(wb_addr) != 0) begin
        m_pend[ix(wb_addr)] = 1'b0;
        m_rf[ix(wb_addr)]   = wb_data;
      end
      if (iss && ix(m_slot.d) != 0) m_pend[ix(m_slot.d)] = 1'b1;
      if (acc) begin
        m_slot   = '{imm: in_imm, mov: in_mov, funct: in_funct, s1: in_src1, s2: in_src2, d: in_dest};
        m_slot_v = 1'b1;
      end else if (iss) begin
        m_slot_v = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      #3;
      check("in_ready", in_ready, m_in_ready());
      check("out_valid", out_valid, m_out_v);
      check("out_fields", {out_imm, out_mov, out_funct, out_src1, out_src2, out_dest},
            {m_out.imm, m_out.mov, m_out.funct, m_out.s1, m_out.s2, m_out.d});
      check("out_operands", {out_read1, out_read2, out_read_dest}, {m_r1, m_r2, m_rd});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic put(input logic imm, input logic mov, input logic [3:0] f,
                     input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] d);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mov   = mov;
    in_funct = f;
    in_src1  = s1;
    in_src2  = s2;
    in_dest  = d;
  endtask

  task automatic wb(input logic [7:0] a, input logic [31:0] dt);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = dt;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_imm = 1'b0; in_mov = 1'b0; in_funct = '0;
    in_src1 = '0; in_src2 = '0; in_dest = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_fields", {out_dest, out_read1, out_read_dest}, '0);

    // Load r5 = 0x10 and r6 = 0x3.
    tick(); wb(8'd5, 32'h10);
    tick(); wb(8'd6, 32'h3);

    // add r7 = r5 + r6, followed at once by subi src1 = r7.
    tick(); wb_en = 1'b0; put(1'b0, 1'b0, F_ADD, 8'd5, 8'd6, 8'd7);
    tick(); put(1'b1, 1'b0, F_SUB, 8'd7, 8'd1, 8'd8);
    settle();
    check("add_not_yet_valid", out_valid, 1'b0);
    tick(); in_valid = 1'b0;
    settle();
    check("add_valid", out_valid, 1'b1);
    check("add_read1", out_read1, 32'h10);
    check("add_read2", out_read2, 32'h3);
    check("subi_stall_in_ready", in_ready, 1'b0);
    tick(); settle();
    check("subi_still_stalled", in_ready, 1'b0);
    tick(); wb(8'd7, 32'h13);
    settle();
    check("subi_released_by_wb", in_ready, 1'b1);
    tick(); wb(8'd8, 32'h12);
    settle();
    check("subi_valid", out_valid, 1'b1);
    check("subi_read1_bypass", out_read1, 32'h13);
    check("subi_read2_zero", out_read2, 32'h0);
    check("subi_src2_imm", out_src2, 8'd1);

    // movh dest = r9 while r9 is pending.
    tick(); wb_en = 1'b0; put(1'b0, 1'b0, F_ADD, 8'd5, 8'd6, 8'd9);
    tick(); put(1'b1, 1'b1, F_SUB, 8'hAB, 8'hCD, 8'd9);
    tick(); in_valid = 1'b0;
    settle();
    check("movh_stall", in_ready, 1'b0);
    tick(); settle();
    check("movh_still_stalled", in_ready, 1'b0);
    tick(); wb(8'd9, 32'h0000ABCD);
    settle();
    check("movh_released", in_ready, 1'b1);
    // movh issue set r9 pending on the same edge that wb cleared it.
    tick(); wb_en = 1'b0; put(1'b0, 1'b0, F_ADD, 8'd9, 8'd5, 8'd15);
    settle();
    check("movh_read_dest", out_read_dest, 32'h0000ABCD);
    check("movh_read1_read2", {out_read1, out_read2}, 64'h0);
    check("movh_src1", out_src1, 8'hAB);
    tick(); in_valid = 1'b0;
    settle();
    check("set_wins_over_clear", in_ready, 1'b0);
    tick(); wb(8'd9, 32'h1234);
    settle();
    check("r9_reader_released", in_ready, 1'b1);
    tick(); wb(8'd15, 32'h0);
    settle();
    check("r9_reader_read1", out_read1, 32'h1234);
    check("r9_reader_read2", out_read2, 32'h10);

    // Back-to-back independent instructions against a blocked output.
    tick(); wb_en = 1'b0; out_ready = 1'b0; put(1'b0, 1'b0, F_ADD, 8'd5, 8'd6, 8'd10);
    tick(); put(1'b0, 1'b0, F_ADD, 8'd5, 8'd6, 8'd11);
    settle();
    check("bp_first_issue_ready", in_ready, 1'b1);
    tick(); put(1'b0, 1'b0, F_ADD, 8'd5, 8'd6, 8'd12);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      settle();
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_bundle_held", {out_valid, out_dest, out_read1}, {1'b1, 8'd10, 32'h10});
    end
    tick(); out_ready = 1'b1;
    settle();
    check("bp_resume_ready", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    settle();
    check("bp_second", {out_valid, out_dest}, {1'b1, 8'd11});
    tick(); settle();
    check("bp_third", {out_valid, out_dest}, {1'b1, 8'd12});
    tick(); settle();
    check("bp_drained", out_valid, 1'b0);
    tick(); wb(8'd10, 32'h100);
    tick(); wb(8'd11, 32'h101);
    tick(); wb(8'd12, 32'h102);

    // Register 0 handling and ignored upper index bits.
    tick(); wb(8'd0, 32'hFFFFFFFF); put(1'b0, 1'b0, F_ADD, 8'd0, 8'd0, 8'd0);
    tick(); put(1'b0, 1'b0, F_AND, 8'd0, 8'd0, 8'd0);
    settle();
    check("r0_no_stall_1", in_ready, 1'b1);
    tick(); wb_en = 1'b0; put(1'b0, 1'b0, F_OR, 8'h85, 8'h40, 8'd0);
    settle();
    check("r0_no_stall_2", in_ready, 1'b1);
    check("r0_reads_zero", {out_read1, out_read2}, 64'h0);
    check("r0_first_funct", out_funct, F_ADD);
    tick(); in_valid = 1'b0;
    settle();
    check("r0_dest_back_to_back", {out_valid, out_funct}, {1'b1, F_AND});
    tick(); settle();
    check("idx_upper_bits_read1", out_read1, 32'h10);
    check("idx_upper_bits_read2", out_read2, 32'h0);
    check("idx_upper_bits_src1", out_src1, 8'h85);

    // Reset while slot and output are both full.
    tick(); out_ready = 1'b0; put(1'b0, 1'b0, F_ADD, 8'd5, 8'd6, 8'd13);
    tick(); put(1'b0, 1'b0, F_ADD, 8'd5, 8'd6, 8'd14);
    tick(); in_valid = 1'b0;
    settle();
    check("pre_reset_full", {out_valid, in_ready}, 2'b10);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    settle();
    check("mid_reset_out_valid", out_valid, 1'b0);
    check("mid_reset_in_ready", in_ready, 1'b1);
    check("mid_reset_fields", {out_dest, out_read1}, '0);
    tick(); out_ready = 1'b1; put(1'b0, 1'b0, F_ADD, 8'd6, 8'd13, 8'd13); wb(8'd5, 32'h77);
    tick(); in_valid = 1'b0; wb_en = 1'b0;
    settle();
    check("mid_reset_pending_cleared", in_ready, 1'b1);
    tick(); put(1'b0, 1'b0, F_ADD, 8'd5, 8'd0, 8'd1);
    settle();
    check("mid_reset_rf_cleared", {out_valid, out_read1, out_read2}, {1'b1, 64'h0});
    tick(); in_valid = 1'b0;
    tick(); settle();
    check("post_reset_wb_read", out_read1, 32'h77);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
